// File: rtl/gw_video_pkg.sv
// Shared video constants: default LCD segment geometry, decay counter width
// and the segment-array shape indexed by the per-pixel renderer.
package gw_video_pkg;

  localparam int unsigned DEF_MAX_X_SEGMENT = 9;
  localparam int unsigned DEF_MAX_Y_SEGMENT = 16;
  localparam int unsigned DEF_MAX_Z_SEGMENT = 4;
  localparam int unsigned DECAY_CNT_W       = 3;

  typedef logic [DEF_MAX_Z_SEGMENT-1:0] seg_frame_t [DEF_MAX_X_SEGMENT][DEF_MAX_Y_SEGMENT];

endpackage

// File: rtl/lcd_segment_cell.sv
// One x.y.z segment: accumulates hits over a frame and publishes its lit bit
// at each frame edge. LCD_SEGMENT_DECAY_EN swaps the accumulator for a persistence counter.
module lcd_segment_cell
  import gw_video_pkg::*;
#(
  parameter int unsigned DECAY_FRAMES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic hit,
  input  logic frame_edge,
  output logic lit
);

`ifdef LCD_SEGMENT_DECAY_EN
  localparam logic [DECAY_CNT_W-1:0] DECAY_LOAD = DECAY_CNT_W'(DECAY_FRAMES);

  logic [DECAY_CNT_W-1:0] cnt;
  logic [DECAY_CNT_W-1:0] cnt_cur;

  // Count entering the edge decides the snapshot, so one hit lights exactly
  // DECAY_FRAMES snapshots (and DECAY_FRAMES=1 matches the base build).
  always_comb begin
    cnt_cur = hit ? DECAY_LOAD : cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      lit <= 1'b0;
    end else if (frame_edge) begin
      lit <= (cnt_cur != '0);
      cnt <= (cnt_cur != '0) ? cnt_cur - DECAY_CNT_W'(1) : '0;
    end else if (hit) begin
      cnt <= DECAY_LOAD;
    end
  end
`else
  logic acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= 1'b0;
      lit <= 1'b0;
    end else if (frame_edge) begin
      lit <= acc | hit;
      acc <= 1'b0;
    end else if (hit) begin
      acc <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/lcd_segment_capture.sv
// Samples the multiplexed LCD drive and publishes a frame-stable segment map
// at every vblank rising edge. Optional persistence: define LCD_SEGMENT_DECAY_EN.
module lcd_segment_capture
  import gw_video_pkg::*;
#(
  parameter int unsigned MAX_X_SEGMENT = DEF_MAX_X_SEGMENT,
  parameter int unsigned MAX_Y_SEGMENT = DEF_MAX_Y_SEGMENT,
  parameter int unsigned MAX_Z_SEGMENT = DEF_MAX_Z_SEGMENT,
  parameter int unsigned DECAY_FRAMES  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic                     lcd_enable,
  input  logic [MAX_Z_SEGMENT-1:0] lcd_h,
  input  logic                     seg_in   [MAX_X_SEGMENT][MAX_Y_SEGMENT],
  input  logic                     vblank_int,
  output logic [MAX_Z_SEGMENT-1:0] segments [MAX_X_SEGMENT][MAX_Y_SEGMENT]
);

  logic                     vblank_q;
  logic                     frame_edge;
  logic [MAX_Z_SEGMENT-1:0] row_hit;

  // Reset to 1 so a vblank already high out of reset is not taken as an edge.
  always_ff @(posedge clk) begin
    if (reset) vblank_q <= 1'b1;
    else       vblank_q <= vblank_int;
  end

  always_comb begin
    frame_edge = vblank_int & ~vblank_q;
    row_hit    = lcd_h & {MAX_Z_SEGMENT{sample_en & lcd_enable}};
  end

  if (DECAY_FRAMES < 1 || DECAY_FRAMES > (1 << DECAY_CNT_W) - 1) begin : g_decay_frames_out_of_range
  end

  for (genvar x = 0; x < MAX_X_SEGMENT; x++) begin : g_x
    for (genvar y = 0; y < MAX_Y_SEGMENT; y++) begin : g_y
      logic [MAX_Z_SEGMENT-1:0] word;

      for (genvar z = 0; z < MAX_Z_SEGMENT; z++) begin : g_z
        lcd_segment_cell #(
          .DECAY_FRAMES (DECAY_FRAMES)
        ) u_cell (
          .clk        (clk),
          .reset      (reset),
          .hit        (row_hit[z] & seg_in[x][y]),
          .frame_edge (frame_edge),
          .lit        (word[z])
        );
      end

      assign segments[x][y] = word;
    end
  end

endmodule

// File: tb/tb_lcd_segment_capture.sv
// Self-checking bench for lcd_segment_capture: directed vector table, decay
// sequence when LCD_SEGMENT_DECAY_EN is defined, then randomized traffic against a frame-level model.
module tb_lcd_segment_capture;
  import gw_video_pkg::*;

  localparam int NX = 9;
  localparam int NY = 16;
  localparam int NZ = 4;
  localparam int D  = 3;
`ifdef LCD_SEGMENT_DECAY_EN
  localparam int DEFF = D;
`else
  localparam int DEFF = 1;
`endif

  logic          clk;
  logic          reset;
  logic          sample_en;
  logic          lcd_enable;
  logic [NZ-1:0] lcd_h;
  logic          seg_in [NX][NY];
  logic          vblank_int;
  logic [NZ-1:0] segments [NX][NY];

  lcd_segment_capture #(
    .MAX_X_SEGMENT (NX),
    .MAX_Y_SEGMENT (NY),
    .MAX_Z_SEGMENT (NZ),
    .DECAY_FRAMES  (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .lcd_enable (lcd_enable),
    .lcd_h      (lcd_h),
    .seg_in     (seg_in),
    .vblank_int (vblank_int),
    .segments   (segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: a segment is lit in snapshot k iff it was hit in a frame f with k-DEFF < f <= k.
  int         last_hit [NX][NY][NZ];
  int         frame_no = 0;
  bit         vq_m = 1'b1;
  seg_frame_t exp_seg;

  typedef struct {
    bit       rst, se, le;
    bit [3:0] h;
    int       sx, sy;
    bit       vb;
    int       ex, ey, ez;
    bit       ebit;
    int       ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit se, bit le, bit [3:0] h, int sx, int sy, bit vb,
                              int ex, int ey, int ez, bit ebit, int ecnt);
    vec_t v;
    v.rst = rst; v.se = se; v.le = le; v.h = h; v.sx = sx; v.sy = sy; v.vb = vb;
    v.ex = ex; v.ey = ey; v.ez = ez; v.ebit = ebit; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic model_reset_state();
    foreach (last_hit[x, y, z]) last_hit[x][y][z] = -1000;
    foreach (exp_seg[x, y]) exp_seg[x][y] = '0;
    vq_m = 1'b1;
  endtask

  task automatic model_tick();
    int cur;
    if (reset) begin
      model_reset_state();
    end else begin
      cur = frame_no + 1;
      foreach (last_hit[x, y, z])
        if (sample_en && lcd_enable && lcd_h[z] && seg_in[x][y]) last_hit[x][y][z] = cur;
      if (vblank_int && !vq_m) begin
        frame_no = cur;
        foreach (last_hit[x, y, z])
          exp_seg[x][y][z] = (last_hit[x][y][z] > frame_no - DEFF);
      end
      vq_m = vblank_int;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic clear_seg();
    foreach (seg_in[x, y]) seg_in[x][y] = 1'b0;
  endtask

  task automatic drive(bit rst, bit se, bit le, bit [3:0] h, int sx, int sy, bit vb);
    reset = rst; sample_en = se; lcd_enable = le; lcd_h = h; vblank_int = vb;
    clear_seg();
    if (sx >= 0) seg_in[sx][sy] = 1'b1;
  endtask

  function automatic int count_lit();
    int n = 0;
    foreach (segments[x, y])
      for (int z = 0; z < NZ; z++) n += int'(segments[x][y][z]);
    return n;
  endfunction

  task automatic check_val(string name, int act, int exp_v);
    checks++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp_v, $time);
  endtask

  task automatic check_model(string name);
    int nbad = 0;
    int bx = 0, by = 0;
    foreach (segments[x, y])
      if (segments[x][y] !== exp_seg[x][y]) begin
        if (nbad == 0) begin bx = x; by = y; end
        nbad++;
      end
    checks++;
    if (nbad == 0) passed++;
    else $display("FAIL %s: segments[%0d][%0d] got %b want %b (%0d words differ) at %0t",
                  name, bx, by, segments[bx][by], exp_seg[bx][by], nbad, $time);
  endtask

  initial begin
    model_reset_state();
    drive(1, 0, 0, 4'b0000, -1, 0, 1);

`ifndef LCD_SEGMENT_DECAY_EN
    // reset held 4 clocks, vblank high out of reset must not publish
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 4'b0000, -1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 1, 0, 0, 0, 0, 0));
    // two idle frames
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'b1111,  3, 5, 1, 3, 5, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 0, 0, 0, 0, 0));
    // single hit, visible only after the edge, cleared next frame
    tbl.push_back(mk(0, 1, 1, 4'b0100,  3, 5, 0, 3, 5, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 3, 5, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 1, 3, 5, 2, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 3, 5, 2, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 1, 3, 5, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 0, 0, 0, 0, 0));
    // gating: lcd_enable low, then sample_en low
    tbl.push_back(mk(0, 1, 0, 4'b0100,  3, 5, 0, 3, 5, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 1, 3, 5, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0100,  3, 5, 0, 3, 5, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 1, 3, 5, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 0, 0, 0, 0, 0));
    // hit in the edge cycle lands in that snapshot
    tbl.push_back(mk(0, 1, 1, 4'b1000,  8, 15, 1, 8, 15, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 8, 15, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 1, 8, 15, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 0, 0, 0, 0, 0));
    // all rows at once
    tbl.push_back(mk(0, 1, 1, 4'b1111,  0, 0, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 1, 0, 0, 3, 1, 4));
    // hit then mid-frame reset discards it
    tbl.push_back(mk(0, 1, 1, 4'b0001,  2, 2, 0, 0, 0, 0, 1, 4));
    tbl.push_back(mk(1, 0, 0, 4'b0000, -1, 0, 0, 2, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 2, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 1, 2, 2, 0, 0, 0));
    // reset dominates a same-cycle hit and vblank rise
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'b0010,  4, 4, 0, 4, 4, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'b0010,  4, 4, 1, 4, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 0, 4, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, -1, 0, 1, 4, 4, 1, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].se, tbl[i].le, tbl[i].h, tbl[i].sx, tbl[i].sy, tbl[i].vb);
      cycle();
      check_val($sformatf("vec%0d_bit", i),
                int'(segments[tbl[i].ex][tbl[i].ey][tbl[i].ez]), int'(tbl[i].ebit));
      check_val($sformatf("vec%0d_count", i), count_lit(), tbl[i].ecnt);
      check_model($sformatf("vec%0d_model", i));
    end
`else
    begin
      int exp_lit [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
      int exp_re  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 4'b0000, -1, 0, 1); cycle(); end
      check_val("decay_reset", count_lit(), 0);
      drive(0, 1, 1, 4'b0010, 1, 1, 0); cycle();
      for (int f = 0; f < 4; f++) begin
        drive(0, 0, 0, 4'b0000, -1, 0, 1); cycle();
        check_val($sformatf("decay_snap%0d", f + 1), int'(segments[1][1][1]), exp_lit[f]);
        check_model($sformatf("decay_snap%0d_model", f + 1));
        drive(0, 0, 0, 4'b0000, -1, 0, 0); cycle();
      end
      drive(0, 1, 1, 4'b0010, 1, 1, 0); cycle();
      for (int f = 0; f < 5; f++) begin
        drive(0, 0, 0, 4'b0000, -1, 0, 1); cycle();
        check_val($sformatf("rehit_snap%0d", f + 1), int'(segments[1][1][1]), exp_re[f]);
        drive(0, 0, 0, 4'b0000, -1, 0, 0); cycle();
        if (f == 0) begin drive(0, 1, 1, 4'b0010, 1, 1, 0); cycle(); end
      end
    end
`endif

    // randomized traffic against the model
    drive(0, 0, 0, 4'b0000, -1, 0, 0);
    for (int c = 0; c < 1200; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      sample_en  = ($urandom_range(0, 1) == 1);
      lcd_enable = ($urandom_range(0, 4) != 0);
      lcd_h      = NZ'($urandom);
      if ($urandom_range(0, 11) == 0) vblank_int = ~vblank_int;
      foreach (seg_in[x, y]) seg_in[x][y] = ($urandom_range(0, 47) == 0);
      cycle();
      check_model($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
